cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_if.sv | 27 ++
 rtl/cpu_run_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// CPU-facing bundle of the run controller: tick/status inputs from the CPU
// and the reset/enable/status outputs back to it.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             tick;
    logic             halt_req;
    logic             instr_done;
    logic             step_mode;
    logic             cpu_reset;
    logic             run_en;
    logic             halted;
    logic             paused;
    logic             want_reset;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output tick, halt_req, instr_done, step_mode,
        input  cpu_reset, run_en, halted, paused, want_reset, state, instr_count
    );

    modport slave (
        input  tick, halt_req, instr_done, step_mode,
        output cpu_reset, run_en, halted, paused, want_reset, state, instr_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt/reset sequencer for a ticked CPU, with debounced front-panel
// buttons, power-on and requested reset pulses, and an instruction counter.
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int POR_TICKS       = 2,
    parameter int RST_TICKS       = 2,
    parameter int NUM_RST_SRC     = 2,
    parameter int CNT_W           = 16
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   btn_reset,
    input  logic                   btn_run,
    input  logic                   btn_step,
    input  logic [NUM_RST_SRC-1:0] rst_src,
    cpu_run_ctrl_if.slave          bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = (POR_TICKS > RST_TICKS) ? POR_TICKS : RST_TICKS;
    localparam int TC_W = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TC_W-1:0] POR_LAST = TC_W'(POR_TICKS - 1);
    localparam logic [TC_W-1:0] RST_LAST = TC_W'(RST_TICKS - 1);

    typedef enum logic [2:0] {
        S_POR    = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSE  = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4,
        S_RST    = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Button debouncers: bit 0 = reset, bit 1 = run, bit 2 = step
    // ------------------------------------------------------------------
    logic [2:0]      btn_raw;
    logic [2:0]      db_lvl;
    logic [2:0]      db_lvl_q;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      click;

    assign btn_raw = {btn_step, btn_run, btn_reset};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            db_lvl   <= '0;
            db_lvl_q <= '0;
            // NOTE: this counter array is only three small registers, so it is
            // reset like ordinary flops rather than left as uninitialised memory.
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            db_lvl_q <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (btn_raw[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= btn_raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign click = db_lvl & ~db_lvl_q;

    logic click_reset, click_run, click_step;
    assign click_reset = click[0];
    assign click_run   = click[1];
    assign click_step  = click[2];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [TC_W-1:0]  tcnt_q, tcnt_d;
    logic             cpu_reset_q;
    logic             want_reset_q;
    logic [CNT_W-1:0] count_q;
    logic             count_inc;
    state_t           exit_state;

    // Leaving a reset samples step_mode; mid-run it is only consulted at instr_done.
    assign exit_state = bus.step_mode ? S_PAUSE : S_RUN;

    // NOTE: every variable is given a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        count_inc = 1'b0;

        unique case (state_q)
            S_POR: begin
                if (bus.tick) begin
                    if (tcnt_q == POR_LAST) state_d = exit_state;
                    else                    tcnt_d  = tcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.tick) begin
                    if (want_reset_q)        state_d = S_RST;
                    else if (bus.halt_req)   state_d = S_HALTED;
                    else if (bus.instr_done) begin
                        count_inc = 1'b1;
                        if (bus.step_mode) state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                // Clicks act without a tick; a ticked reset request beats them.
                if (bus.tick && want_reset_q) state_d = S_RST;
                else if (click_step)          state_d = S_STEP;
                else if (click_run)           state_d = S_RUN;
            end
            S_STEP: begin
                if (bus.tick) begin
                    if (want_reset_q)        state_d = S_RST;
                    else if (bus.halt_req)   state_d = S_HALTED;
                    else if (bus.instr_done) begin
                        count_inc = 1'b1;
                        state_d   = S_PAUSE;
                    end
                end
            end
            S_HALTED: begin
                if (bus.tick && want_reset_q) state_d = S_RST;
            end
            S_RST: begin
                if (bus.tick) begin
                    if (tcnt_q == RST_LAST) state_d = exit_state;
                    else                    tcnt_d  = tcnt_q + 1'b1;
                end
            end
            default: state_d = S_POR;
        endcase

        if (state_d == S_RST && state_q != S_RST) tcnt_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_POR;
            tcnt_q       <= '0;
            cpu_reset_q  <= 1'b1;
            want_reset_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;

            // Every entry to or exit from POR/RST is ticked, so this tracks the state.
            if (bus.tick) cpu_reset_q <= (state_d == S_POR) || (state_d == S_RST);

            if (state_d == S_RST && state_q != S_RST)
                want_reset_q <= 1'b0;
            else if (!cpu_reset_q && (click_reset || (|rst_src)))
                want_reset_q <= 1'b1;

            if (state_d == S_POR || state_d == S_RST) count_q <= '0;
            else if (count_inc)                       count_q <= count_q + 1'b1;
        end
    end

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.run_en      = (state_q == S_RUN) || (state_q == S_STEP);
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.paused      = (state_q == S_PAUSE);
    assign bus.want_reset  = want_reset_q;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Vector/scoreboard bench for cpu_run_ctrl with default parameters.
module tb_cpu_run_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic       btn_reset, btn_run, btn_step;
    logic [1:0] rst_src;

    cpu_run_ctrl_if #(.CNT_W(16)) bus ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4), .POR_TICKS(2), .RST_TICKS(2),
        .NUM_RST_SRC(2), .CNT_W(16)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .btn_reset(btn_reset),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .rst_src  (rst_src),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  st;
        logic        crst;
        logic        wr;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic       rst, tick, halt, done, smode;
        logic [1:0] rs;
        logic       br, brn, bst;
        exp_t       exp;
    } vec_t;

    exp_t sb [$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, tk, hl, dn, sm, input logic [1:0] rs,
                                input logic br, brn, bst, input logic [2:0] st,
                                input logic crst, wr, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.tick = tk; v.halt = hl; v.done = dn; v.smode = sm; v.rs = rs;
        v.br = br; v.brn = brn; v.bst = bst;
        v.exp.st = st; v.exp.crst = crst; v.exp.wr = wr; v.exp.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", name, n_vec, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        reset         = v.rst;
        bus.tick       = v.tick;
        bus.halt_req   = v.halt;
        bus.instr_done = v.done;
        bus.step_mode  = v.smode;
        rst_src       = v.rs;
        btn_reset     = v.br;
        btn_run       = v.brn;
        btn_step      = v.bst;
        sb.push_back(v.exp);
        @(posedge CLK);
        #1;
        n_vec++;
        e = sb.pop_front();
        check("state",       32'(bus.state),       32'(e.st));
        check("run_en",      32'(bus.run_en),      32'(e.st == 3'd1 || e.st == 3'd3));
        check("cpu_reset",   32'(bus.cpu_reset),   32'(e.crst));
        check("want_reset",  32'(bus.want_reset),  32'(e.wr));
        check("halted",      32'(bus.halted),      32'(e.st == 3'd4));
        check("paused",      32'(bus.paused),      32'(e.st == 3'd2));
        check("instr_count", 32'(bus.instr_count), 32'(e.cnt));
    endtask

    vec_t tbl [21];

    initial begin
        reset = 1'b1; bus.tick = 0; bus.halt_req = 0; bus.instr_done = 0; bus.step_mode = 0;
        rst_src = '0; btn_reset = 0; btn_run = 0; btn_step = 0;

        //            rst tk hl dn sm rs    br brn bst  st   crst wr cnt
        tbl[0]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 1, 0, 16'd0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 1, 0, 16'd0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 1, 0, 16'd0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd0, 1, 0, 16'd0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd0);
        tbl[5]  = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd1);
        tbl[6]  = mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd1);
        tbl[7]  = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd2);
        tbl[8]  = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd3);
        tbl[9]  = mk(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 3'd4, 0, 0, 16'd3);
        tbl[10] = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 3'd4, 0, 0, 16'd3);
        tbl[11] = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 3'd4, 0, 1, 16'd3);
        tbl[12] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'd4, 0, 1, 16'd3);
        tbl[13] = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'd5, 1, 0, 16'd0);
        tbl[14] = mk(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 3'd5, 1, 0, 16'd0);
        tbl[15] = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd0);
        tbl[16] = mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 3'd1, 0, 0, 16'd1);
        tbl[17] = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 3'd1, 0, 1, 16'd1);
        tbl[18] = mk(0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 3'd5, 1, 0, 16'd0);
        tbl[19] = mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 3'd5, 1, 0, 16'd0);
        tbl[20] = mk(0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 3'd2, 0, 0, 16'd0);

        @(negedge CLK);
        for (int i = 0; i < 21; i++) drive(tbl[i]);

        // Step click from PAUSE, then one instruction back to PAUSE
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,1,2'b00,0,0,1, 3'd2,0,0,16'd0));
        drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd3,0,0,16'd0));
        for (int i = 0; i < 3; i++) drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd3,0,0,16'd0));
        drive(mk(0,1,0,1,1,2'b00,0,0,0, 3'd2,0,0,16'd1));

        // Bouncing step button gives no click; a clean press gives exactly one
        for (int i = 0; i < 12; i++)
            drive(mk(0,0,0,0,1,2'b00,0,0,((i % 4) < 2), 3'd2,0,0,16'd1));
        for (int i = 0; i < 2; i++) drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd2,0,0,16'd1));
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,1,2'b00,0,0,1, 3'd2,0,0,16'd1));
        drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd3,0,0,16'd1));
        for (int i = 0; i < 3; i++) drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd3,0,0,16'd1));
        drive(mk(0,1,0,1,1,2'b00,0,0,0, 3'd2,0,0,16'd2));
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd2,0,0,16'd2));

        // Ticked reset request in PAUSE wins over a coincident step click
        drive(mk(0,0,0,0,1,2'b01,0,0,1, 3'd2,0,1,16'd2));
        for (int i = 0; i < 3; i++) drive(mk(0,0,0,0,1,2'b00,0,0,1, 3'd2,0,1,16'd2));
        drive(mk(0,1,0,0,1,2'b00,0,0,0, 3'd5,1,0,16'd0));
        drive(mk(0,1,0,0,1,2'b00,0,0,0, 3'd5,1,0,16'd0));
        drive(mk(0,1,0,0,1,2'b00,0,0,0, 3'd2,0,0,16'd0));
        drive(mk(0,0,0,0,1,2'b00,0,0,0, 3'd2,0,0,16'd0));

        // Run click from PAUSE, retire one, halt; run click ignored in HALTED
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,1,2'b00,0,1,0, 3'd2,0,0,16'd0));
        drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd1,0,0,16'd0));
        for (int i = 0; i < 3; i++) drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd1,0,0,16'd0));
        drive(mk(0,1,0,1,0,2'b00,0,0,0, 3'd1,0,0,16'd1));
        drive(mk(0,1,1,0,0,2'b00,0,0,0, 3'd4,0,0,16'd1));
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,0,2'b00,0,1,0, 3'd4,0,0,16'd1));
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd4,0,0,16'd1));

        // Reset button from HALTED through RST back to RUN
        for (int i = 0; i < 4; i++) drive(mk(0,0,0,0,0,2'b00,1,0,0, 3'd4,0,0,16'd1));
        drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd4,0,1,16'd1));
        drive(mk(0,1,0,0,0,2'b00,0,0,0, 3'd5,1,0,16'd0));
        drive(mk(0,1,0,0,0,2'b00,0,0,0, 3'd5,1,0,16'd0));
        drive(mk(0,1,0,0,0,2'b00,0,0,0, 3'd1,0,0,16'd0));
        drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd1,0,0,16'd0));

        // Block reset in the middle of running
        drive(mk(0,1,0,1,0,2'b00,0,0,0, 3'd1,0,0,16'd1));
        drive(mk(1,0,0,0,0,2'b00,0,0,0, 3'd0,1,0,16'd0));
        drive(mk(0,0,0,0,0,2'b00,0,0,0, 3'd0,1,0,16'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
